// File: rtl/fsm_run_arbiter_if.sv
// Request/grant handshake and five-state sequence FSM drive bus for fsm_run_arbiter.
// master: the arbiter side; slave: the requesters plus the shared FSM instance.
interface fsm_run_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] err;
  logic               busy;
  logic               fsm_A;
  logic               fsm_B;
  logic               fsm_C;
  logic [3:0]         fsm_D;
  logic               fsm_rstN;
  logic [2:0]         fsm_Q;

  modport master (
    input  req,
    input  fsm_Q,
    output gnt,
    output done,
    output err,
    output busy,
    output fsm_A,
    output fsm_B,
    output fsm_C,
    output fsm_D,
    output fsm_rstN
  );

  modport slave (
    output req,
    output fsm_Q,
    input  gnt,
    input  done,
    input  err,
    input  busy,
    input  fsm_A,
    input  fsm_B,
    input  fsm_C,
    input  fsm_D,
    input  fsm_rstN
  );
endinterface

// File: rtl/fsm_run_arbiter.sv
// Round-robin arbiter that walks one shared five-state sequence FSM through S0..S4 per grant.
// Define FSM_RUN_STATS_EN to add saturating run_cnt/err_cnt outputs.
module fsm_run_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 15,
  parameter logic [3:0]  D_CODE1 = 4'b0100,
  parameter logic [3:0]  D_CODE2 = 4'b1000
) (
  input  logic               clk,
  input  logic               rstN,
`ifdef FSM_RUN_STATS_EN
  output logic [7:0]         run_cnt,
  output logic [7:0]         err_cnt,
`endif
  fsm_run_arbiter_if.master  bus
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IdxW-1:0]    LastIdx    = IdxW'(NUM_REQ - 1);
  localparam logic [7:0]         TimeoutCnt = 8'(TIMEOUT);
  localparam logic [NUM_REQ-1:0] OneHot0    = {{(NUM_REQ-1){1'b0}}, 1'b1};

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWaitS1 = 3'd1;
  localparam logic [2:0] StWaitS2 = 3'd2;
  localparam logic [2:0] StWaitS3 = 3'd3;
  localparam logic [2:0] StWaitS4 = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;
  localparam logic [2:0] StAbort  = 3'd6;

  logic [2:0]      state_q, state_d;
  logic [IdxW-1:0] gidx_q, gidx_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [7:0]      cnt_q, cnt_d;

  logic            pick_vld;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] cand;

  logic [2:0]      exp_q;
  logic [2:0]      w_next;
  logic            in_wait;
  logic            q_hit;

  logic [NUM_REQ-1:0] gidx_oh;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] err;
  logic               drv_a;
  logic               drv_b;
  logic [3:0]         drv_d;

  // First set request at or after the rr pointer, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IdxW'((32'(rr_q) + i) % NUM_REQ);
      if (!pick_vld && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    exp_q   = 3'b000;
    w_next  = StIdle;
    in_wait = 1'b1;
    case (state_q)
      StWaitS1: begin
        exp_q  = 3'b011;
        w_next = StWaitS2;
      end
      StWaitS2: begin
        exp_q  = 3'b100;
        w_next = StWaitS3;
      end
      StWaitS3: begin
        exp_q  = 3'b000;
        w_next = StWaitS4;
      end
      StWaitS4: begin
        exp_q  = 3'b111;
        w_next = StDone;
      end
      default: in_wait = 1'b0;
    endcase
  end

  assign q_hit = in_wait && (bus.fsm_Q == exp_q);

  // A match on the same cycle the counter reaches TIMEOUT still advances.
  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d = StWaitS1;
          gidx_d  = pick_idx;
          rr_d    = (pick_idx == LastIdx) ? '0 : pick_idx + 1'b1;
          cnt_d   = '0;
        end
      end
      StWaitS1, StWaitS2, StWaitS3, StWaitS4: begin
        if (q_hit) begin
          state_d = w_next;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutCnt) begin
          state_d = StAbort;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= StIdle;
      gidx_q  <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gidx_oh = OneHot0 << gidx_q;

  always_comb begin
    gnt   = '0;
    done  = '0;
    err   = '0;
    drv_a = 1'b0;
    drv_b = 1'b0;
    drv_d = 4'b0000;
    case (state_q)
      StWaitS1: begin
        gnt   = gidx_oh;
        drv_b = 1'b1;
      end
      StWaitS2: begin
        gnt   = gidx_oh;
        drv_d = D_CODE1;
      end
      StWaitS3: begin
        gnt   = gidx_oh;
        drv_a = 1'b1;
        drv_b = 1'b1;
      end
      StWaitS4: begin
        gnt   = gidx_oh;
        drv_d = D_CODE2;
      end
      StDone:  done = gidx_oh;
      StAbort: err  = gidx_oh;
      default: ;
    endcase
  end

  assign bus.gnt      = gnt;
  assign bus.done     = done;
  assign bus.err      = err;
  assign bus.busy     = (state_q != StIdle);
  assign bus.fsm_A    = drv_a;
  assign bus.fsm_B    = drv_b;
  assign bus.fsm_C    = 1'b0;
  assign bus.fsm_D    = drv_d;
  // Held low with the system reset and for the single abort cycle.
  assign bus.fsm_rstN = rstN & (state_q != StAbort);

`ifdef FSM_RUN_STATS_EN
  logic [7:0] run_cnt_q;
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      run_cnt_q <= 8'h00;
      err_cnt_q <= 8'h00;
    end else begin
      if (state_q == StDone && run_cnt_q != 8'hFF) begin
        run_cnt_q <= run_cnt_q + 8'd1;
      end
      if (state_q == StAbort && err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign run_cnt = run_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_fsm_run_arbiter.sv
// Directed bench for fsm_run_arbiter with a behavioural five-state sequence FSM attached.
module tb_fsm_run_arbiter;

  logic clk = 1'b0;
  logic rstN;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fsm_run_arbiter_if #(.NUM_REQ(4)) bus ();

`ifdef FSM_RUN_STATS_EN
  logic [7:0] run_cnt;
  logic [7:0] err_cnt;
`endif

  fsm_run_arbiter #(
    .NUM_REQ(4),
    .TIMEOUT(15),
    .D_CODE1(4'b0100),
    .D_CODE2(4'b1000)
  ) dut (
    .clk    (clk),
    .rstN   (rstN),
`ifdef FSM_RUN_STATS_EN
    .run_cnt(run_cnt),
    .err_cnt(err_cnt),
`endif
    .bus    (bus)
  );

  // Sequence FSM model: Q shows the code of the state being entered.
  // stall_s1 pins the model in S1 to provoke timeouts.
  logic       stall_s1;
  logic       fsm_rstn;
  logic [2:0] ms, ms_n, mq;
  logic [6:0] drv;

  assign fsm_rstn  = bus.fsm_rstN;
  assign drv       = {bus.fsm_A, bus.fsm_B, bus.fsm_C, bus.fsm_D};
  assign bus.fsm_Q = mq;

  always_comb begin
    ms_n = ms;
    if (!(stall_s1 && ms == 3'd1)) begin
      case (ms)
        3'd0: if (bus.fsm_B && !bus.fsm_A) ms_n = 3'd1;
        3'd1: if (bus.fsm_D == 4'b0100) ms_n = 3'd2;
        3'd2: if (bus.fsm_A && bus.fsm_B) ms_n = 3'd3;
        3'd3: if (bus.fsm_D == 4'b1000) ms_n = 3'd4;
        default: ms_n = 3'd0;
      endcase
    end
  end

  always_comb begin
    mq = 3'b001;
    case (ms_n)
      3'd1: mq = 3'b011;
      3'd2: mq = 3'b100;
      3'd3: mq = 3'b000;
      3'd4: mq = 3'b111;
      default: mq = 3'b001;
    endcase
  end

  always_ff @(posedge clk or negedge fsm_rstn) begin
    if (!fsm_rstn) ms <= 3'd0;
    else           ms <= ms_n;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clean run from IDLE; leaves the arbiter back in IDLE.
  task automatic do_run(input logic [3:0] r, input logic [3:0] exp_g);
    bus.req = r;
    tick();
    check("run_gnt", bus.gnt, exp_g);
    bus.req = 4'b0000;
    repeat (3) tick();
    tick();
    check("run_done", bus.done, exp_g);
    tick();
  endtask

  logic [3:0] rr_exp [5];

  initial begin
    rstN     = 1'b0;
    bus.req  = 4'b0000;
    stall_s1 = 1'b0;
    rr_exp   = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    tick();
    tick();
    check("rst_gnt", bus.gnt, 4'b0000);
    check("rst_flags", {bus.done, bus.err, 3'b000, bus.busy}, 12'h000);
    check("rst_drv", drv, 7'b000_0000);
    check("rst_frst", bus.fsm_rstN, 1'b0);
    rstN = 1'b1;
    #1;
    check("rel_frst", bus.fsm_rstN, 1'b1);

    // Single requester, dropping req after grant.
    bus.req = 4'b0001;
    tick();
    check("s_gnt", bus.gnt, 4'b0001);
    check("s_busy", bus.busy, 1'b1);
    check("s_drv1", drv, 7'b010_0000);
    bus.req = 4'b0000;
    tick();
    check("s_drv2", drv, 7'b000_0100);
    tick();
    check("s_drv3", drv, 7'b110_0000);
    tick();
    check("s_drv4", drv, 7'b000_1000);
    tick();
    check("s_done", bus.done, 4'b0001);
    check("s_dgnt", bus.gnt, 4'b0000);
    check("s_ddrv", drv, 7'b000_0000);
    tick();
    check("s_done0", bus.done, 4'b0000);
    check("s_idle", bus.busy, 1'b0);

    // Round-robin with all requests held; rr starts at 1.
    bus.req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      tick();
      check("rr_gnt", bus.gnt, rr_exp[r]);
      repeat (3) tick();
      tick();
      check("rr_done", bus.done, rr_exp[r]);
      check("rr_dgnt", bus.gnt, 4'b0000);
      tick();
      check("rr_igpt", bus.gnt, 4'b0000);
      check("rr_ibsy", bus.busy, 1'b0);
    end
    bus.req = 4'b0000;

    // Timeout in W_S2; rr=2 so 1010 grants bit 3, then bit 1 after abort.
    stall_s1 = 1'b1;
    bus.req  = 4'b1010;
    tick();
    check("to_gnt", bus.gnt, 4'b1000);
    repeat (16) tick();
    check("to_last_gnt", bus.gnt, 4'b1000);
    check("to_last_err", bus.err, 4'b0000);
    tick();
    check("to_err", bus.err, 4'b1000);
    check("to_frst", bus.fsm_rstN, 1'b0);
    check("to_agnt", bus.gnt, 4'b0000);
    check("to_adone", bus.done, 4'b0000);
    stall_s1 = 1'b0;
    tick();
    check("to_ierr", bus.err, 4'b0000);
    check("to_ifrst", bus.fsm_rstN, 1'b1);
    check("to_igpt", bus.gnt, 4'b0000);
    tick();
    check("to_next", bus.gnt, 4'b0010);
    bus.req = 4'b0000;
    repeat (3) tick();
    tick();
    check("to_ndone", bus.done, 4'b0010);
    tick();

    // Q match arrives on the cycle the counter equals TIMEOUT.
    stall_s1 = 1'b1;
    bus.req  = 4'b0001;
    tick();
    check("bd_gnt", bus.gnt, 4'b0001);
    bus.req = 4'b0000;
    repeat (16) tick();
    stall_s1 = 1'b0;
    tick();
    check("bd_s3drv", drv, 7'b110_0000);
    check("bd_err", bus.err, 4'b0000);
    tick();
    tick();
    check("bd_done", bus.done, 4'b0001);
    check("bd_derr", bus.err, 4'b0000);
    tick();

    // Reset during W_S3.
    bus.req = 4'b0010;
    tick();
    check("mr_gnt", bus.gnt, 4'b0010);
    tick();
    tick();
    check("mr_s3", drv, 7'b110_0000);
    rstN = 1'b0;
    #1;
    check("mr_agnt", bus.gnt, 4'b0000);
    check("mr_adrv", drv, 7'b000_0000);
    check("mr_afrst", bus.fsm_rstN, 1'b0);
    check("mr_abusy", bus.busy, 1'b0);
    tick();
    check("mr_pulse", {bus.done, bus.err}, 8'h00);
    rstN = 1'b1;
    tick();
    check("mr_regnt", bus.gnt, 4'b0010);
    bus.req = 4'b0000;
    repeat (3) tick();
    tick();
    check("mr_done", bus.done, 4'b0010);
    tick();

`ifdef FSM_RUN_STATS_EN
    rstN = 1'b0;
    #1;
    check("st_rrun", run_cnt, 8'd0);
    check("st_rerr", err_cnt, 8'd0);
    tick();
    rstN = 1'b1;
    for (int k = 0; k < 3; k++) do_run(4'b0001, 4'b0001);
    stall_s1 = 1'b1;
    bus.req  = 4'b0001;
    tick();
    bus.req = 4'b0000;
    repeat (16) tick();
    tick();
    check("st_abort", bus.err, 4'b0001);
    stall_s1 = 1'b0;
    tick();
    check("st_run3", run_cnt, 8'd3);
    check("st_err1", err_cnt, 8'd1);
    for (int k = 0; k < 300; k++) do_run(4'b0001, 4'b0001);
    check("st_sat", run_cnt, 8'hFF);
    check("st_err1b", err_cnt, 8'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
